// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA/SVGA sync, data-enable and pixel address generator
module vga_timing_gen #(
  parameter int H_SYNC   = 80,
  parameter int H_BACK   = 160,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 21,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int LEAD     = 2,
  parameter int CW       = 11
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          Pix_En,
  output logic          HSYNC_Sig,
  output logic          VSYNC_Sig,
  output logic          Ready_Sig,
  output logic [CW-1:0] Column_Addr_Sig,
  output logic [CW-1:0] Row_Addr_Sig,
  output logic          Addr_Valid_Sig,
  output logic          Frame_Start_Sig,
  output logic          Line_Start_Sig
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_W  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_W  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_BEG = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_ACT_END = CW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_BEG = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_SYNC + V_BACK + V_ACTIVE);

  logic [CW-1:0] count_h;
  logic [CW-1:0] count_v;
  logic [CW-1:0] col_next;
  logic [CW-1:0] row_next;
  logic          hs_raw;
  logic          vs_raw;
  logic          h_act;
  logic          v_act;
  logic          act;
  logic          a_hs;
  logic          a_vs;
  logic          d_hs;
  logic          d_vs;
  logic          d_valid;

  assign hs_raw   = (count_h < H_SYNC_W);
  assign vs_raw   = (count_v < V_SYNC_W);
  assign h_act    = (count_h >= H_ACT_BEG) && (count_h < H_ACT_END);
  assign v_act    = (count_v >= V_ACT_BEG) && (count_v < V_ACT_END);
  assign act      = h_act && v_act;
  // Wraps below the window are harmless: only consumed when act is high.
  assign col_next = count_h - H_ACT_BEG;
  assign row_next = count_v - V_ACT_BEG;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      count_h <= '0;
      count_v <= '0;
    end else if (Pix_En) begin
      if (count_h == H_LAST) begin
        count_h <= '0;
        count_v <= (count_v == V_LAST) ? '0 : count_v + 1'b1;
      end else begin
        count_h <= count_h + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      a_hs            <= 1'b0;
      a_vs            <= 1'b0;
      Addr_Valid_Sig  <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
      Frame_Start_Sig <= 1'b0;
      Line_Start_Sig  <= 1'b0;
    end else if (Pix_En) begin
      a_hs            <= hs_raw;
      a_vs            <= vs_raw;
      Addr_Valid_Sig  <= act;
      Column_Addr_Sig <= act ? col_next : '0;
      Row_Addr_Sig    <= act ? row_next : '0;
      Frame_Start_Sig <= act && (col_next == '0) && (row_next == '0);
      Line_Start_Sig  <= act && (col_next == '0);
    end
  end

  // Video outputs trail the addresses by LEAD enabled cycles.
  generate
    if (LEAD == 0) begin : g_nolead
      assign d_hs    = a_hs;
      assign d_vs    = a_vs;
      assign d_valid = Addr_Valid_Sig;
    end else begin : g_lead
      logic [LEAD-1:0][2:0] sr;
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          sr <= '0;
        end else if (Pix_En) begin
          sr[0] <= {a_hs, a_vs, Addr_Valid_Sig};
          for (int i = 1; i < LEAD; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end
      assign {d_hs, d_vs, d_valid} = sr[LEAD-1];
    end
  endgenerate

  assign HSYNC_Sig = ~(d_hs ^ HS_POL);
  assign VSYNC_Sig = ~(d_vs ^ VS_POL);
  assign Ready_Sig = d_valid;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen in small, lead, inverted and default modes
module tb_vga_timing_gen;

  logic CLK    = 1'b0;
  logic RST_n  = 1'b0;
  logic Pix_En = 1'b0;

  always #5 CLK = ~CLK;

  logic        hs0, vs0, rd0, av0, fs0, ls0;
  logic [3:0]  c0, r0;
  logic        hs3, vs3, rd3, av3, fs3, ls3;
  logic [3:0]  c3, r3;
  logic        hsn, vsn, rdn, avn, fsn, lsn;
  logic [3:0]  cn, rn;
  logic        hsd, vsd, rdd, avd, fsd, lsd;
  logic [10:0] cd, rd;

  vga_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(1), .V_SYNC(1), .V_BACK(2),
                   .V_ACTIVE(4), .V_FRONT(1), .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(0), .CW(4)) u0 (
    .CLK(CLK), .RST_n(RST_n), .Pix_En(Pix_En), .HSYNC_Sig(hs0), .VSYNC_Sig(vs0), .Ready_Sig(rd0),
    .Column_Addr_Sig(c0), .Row_Addr_Sig(r0), .Addr_Valid_Sig(av0), .Frame_Start_Sig(fs0),
    .Line_Start_Sig(ls0));

  vga_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(1), .V_SYNC(1), .V_BACK(2),
                   .V_ACTIVE(4), .V_FRONT(1), .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(3), .CW(4)) u3 (
    .CLK(CLK), .RST_n(RST_n), .Pix_En(Pix_En), .HSYNC_Sig(hs3), .VSYNC_Sig(vs3), .Ready_Sig(rd3),
    .Column_Addr_Sig(c3), .Row_Addr_Sig(r3), .Addr_Valid_Sig(av3), .Frame_Start_Sig(fs3),
    .Line_Start_Sig(ls3));

  vga_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(1), .V_SYNC(1), .V_BACK(2),
                   .V_ACTIVE(4), .V_FRONT(1), .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(2), .CW(4)) un (
    .CLK(CLK), .RST_n(RST_n), .Pix_En(Pix_En), .HSYNC_Sig(hsn), .VSYNC_Sig(vsn), .Ready_Sig(rdn),
    .Column_Addr_Sig(cn), .Row_Addr_Sig(rn), .Addr_Valid_Sig(avn), .Frame_Start_Sig(fsn),
    .Line_Start_Sig(lsn));

  vga_timing_gen #(.LEAD(2), .CW(11)) ud (
    .CLK(CLK), .RST_n(RST_n), .Pix_En(Pix_En), .HSYNC_Sig(hsd), .VSYNC_Sig(vsd), .Ready_Sig(rdd),
    .Column_Addr_Sig(cd), .Row_Addr_Sig(rd), .Addr_Valid_Sig(avd), .Frame_Start_Sig(fsd),
    .Line_Start_Sig(lsd));

  logic [27:0] sb [$];
  int n = 0;
  int total = 0;
  int bad = 0;
  int clk_idx = 0;
  bit phase3 = 1'b0;
  logic fs0_prev = 1'b0;
  int fs_rise [$];
  int hs_cnt = 0, vs_cnt = 0, rd_cnt = 0, hsn_low = 0, rd3_cnt = 0;
  int mc0 = 0, mr0 = 0, mcd = 0;
  int ls_first = -1, ls_second = -1;

  function automatic logic [27:0] get_obs(input int idx);
    case (idx)
      0:       return {hs0, vs0, rd0, av0, fs0, ls0, 7'd0, c0, 7'd0, r0};
      1:       return {hs3, vs3, rd3, av3, fs3, ls3, 7'd0, c3, 7'd0, r3};
      2:       return {hsn, vsn, rdn, avn, fsn, lsn, 7'd0, cn, 7'd0, rn};
      default: return {hsd, vsd, rdd, avd, fsd, lsd, cd, rd};
    endcase
  endfunction

  // Outputs after k enabled edges: addresses describe raster position k-1, video k-1-LEAD.
  function automatic logic [27:0] model(input int idx, input int k);
    int hsy, hbp, hac, hfp, vsy, vbp, vac, vfp, ld, ht, vt, p, h, v;
    bit hp, vp;
    logic av, hr, vr, dv, f, l;
    logic [10:0] col, row;
    hsy = 2; hbp = 3; hac = 8; hfp = 1; vsy = 1; vbp = 2; vac = 4; vfp = 1;
    hp = 1'b1; vp = 1'b1; ld = 0;
    case (idx)
      1: ld = 3;
      2: begin ld = 2; hp = 1'b0; vp = 1'b0; end
      3: begin
        hsy = 80; hbp = 160; hac = 800; hfp = 16; vsy = 3; vbp = 21; vac = 600; vfp = 1; ld = 2;
      end
      default: ;
    endcase
    ht = hsy + hbp + hac + hfp;
    vt = vsy + vbp + vac + vfp;
    av = 1'b0; hr = 1'b0; vr = 1'b0; dv = 1'b0; f = 1'b0; l = 1'b0; col = '0; row = '0;
    if (k >= 1) begin
      p = k - 1; h = p % ht; v = (p / ht) % vt;
      av = (h >= hsy + hbp) && (h < hsy + hbp + hac) && (v >= vsy + vbp) && (v < vsy + vbp + vac);
      if (av) begin
        col = 11'(h - hsy - hbp);
        row = 11'(v - vsy - vbp);
      end
      f = av && (col == 0) && (row == 0);
      l = av && (col == 0);
    end
    if (k - 1 - ld >= 0) begin
      p = k - 1 - ld; h = p % ht; v = (p / ht) % vt;
      hr = (h < hsy);
      vr = (v < vsy);
      dv = (h >= hsy + hbp) && (h < hsy + hbp + hac) && (v >= vsy + vbp) && (v < vsy + vbp + vac);
    end
    return {hr ? hp : ~hp, vr ? vp : ~vp, dv, av, f, l, col, row};
  endfunction

  task automatic check(input string tag, input logic [27:0] o, input logic [27:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s n=%0d clk=%0d observed=%h expected=%h", tag, n, clk_idx, o, e);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_u%0d", tag, i), get_obs(i), sb.pop_front());
    end
  endtask

  task automatic stats(input bit adv);
    if (adv) begin
      if (n >= 225 && n <= 336) begin
        if (hs0) hs_cnt++;
        if (vs0) vs_cnt++;
        if (rd0) rd_cnt++;
        if (!hsn) hsn_low++;
        if (rd3) rd3_cnt++;
      end
      if (av0 && int'(c0) > mc0) mc0 = int'(c0);
      if (av0 && int'(r0) > mr0) mr0 = int'(r0);
      if (avd && int'(cd) > mcd) mcd = int'(cd);
      if (lsd) begin
        if (ls_first < 0) ls_first = n;
        else if (ls_second < 0) ls_second = n;
      end
    end
    if (phase3 && fs0 && !fs0_prev) fs_rise.push_back(clk_idx);
    fs0_prev = fs0;
  endtask

  task automatic step(input bit pe, input bit rstv);
    @(negedge CLK);
    Pix_En = pe;
    RST_n  = rstv;
    if (!rstv) n = 0;
    else if (pe) n++;
    for (int i = 0; i < 4; i++) sb.push_back(model(i, n));
    @(posedge CLK);
    #1;
    clk_idx++;
    compare_all("cyc");
    stats(pe && rstv);
  endtask

  initial begin
    #1;
    for (int i = 0; i < 4; i++) sb.push_back(model(i, 0));
    compare_all("reset_init");
    repeat (4) step(1'b1, 1'b0);
    repeat (191) step(1'b1, 1'b1);

    // Raster now at Count_H=9, Count_V=5 of the small modes; reset between clock edges.
    RST_n = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) sb.push_back(model(i, 0));
    #1;
    compare_all("async_rst");
    repeat (3) step(1'b1, 1'b0);

    phase3 = 1'b1;
    for (int i = 0; i < 600; i++) step((i % 3) == 0, 1'b1);
    phase3 = 1'b0;
    check("frame_clks", 28'(fs_rise.size() >= 2 ? fs_rise[1] - fs_rise[0] : -1), 28'd336);

    repeat (26600) step(1'b1, 1'b1);
    check("hsync_high_per_frame", 28'(hs_cnt), 28'd16);
    check("vsync_high_per_frame", 28'(vs_cnt), 28'd14);
    check("ready_per_frame", 28'(rd_cnt), 28'd32);
    check("inv_hsync_low_per_frame", 28'(hsn_low), 28'd16);
    check("lead3_ready_per_frame", 28'(rd3_cnt), 28'd32);
    check("small_max_col", 28'(mc0), 28'd7);
    check("small_max_row", 28'(mr0), 28'd3);
    check("dflt_max_col", 28'(mcd), 28'd799);
    check("dflt_line_period", 28'(ls_second >= 0 ? ls_second - ls_first : -1), 28'd1056);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
